// File: rtl/draw_board_cells.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | draw_board_cells: N x N board-cell renderer on the VGA timing chain.    |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module draw_board_cells #(
    parameter int unsigned N            = 3,
    parameter int unsigned GRID_X0      = 8,
    parameter int unsigned GRID_Y0      = 9,
    parameter int unsigned CELL_W       = 336,
    parameter int unsigned CELL_H       = 253,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] COLOR_P0     = 12'h00f,
    parameter logic [11:0] COLOR_P1     = 12'hff0,
    parameter logic [11:0] COLOR_CUR    = 12'h0f0
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [10:0]        hcount_in,
    input  logic               hsync_in,
    input  logic               hblnk_in,
    input  logic [10:0]        vcount_in,
    input  logic               vsync_in,
    input  logic               vblnk_in,
    input  logic [11:0]        rgb_in,
    input  logic               start_en,
    input  logic               choice_en,
    input  logic [2*N*N-1:0]   cell_owner,
    input  logic [N*N-1:0]     win_mask,
    input  logic               cursor_en,
    input  logic [IDX_W-1:0]   cursor_idx,
    output logic [10:0]        hcount_out,
    output logic               hsync_out,
    output logic               hblnk_out,
    output logic [10:0]        vcount_out,
    output logic               vsync_out,
    output logic               vblnk_out,
    output logic [11:0]        rgb_out
);

    localparam int unsigned NN   = N * N;
    localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [31:0] X_HI = GRID_X0 + N * CELL_W;
    localparam logic [31:0] Y_HI = GRID_Y0 + N * CELL_H;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    // Frame-coherent board state
    logic              vsync_d_q;
    logic [2*NN-1:0]   owner_sh_q;
    logic [NN-1:0]     win_sh_q;
    logic              cur_en_sh_q;
    logic [IDX_W-1:0]  cur_idx_sh_q;
    logic [FC_W-1:0]   frame_cnt_q;
    logic              blink_ph_q;
    logic              w_vsync_rise;

    assign w_vsync_rise = vsync_in & ~vsync_d_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_d_q    <= 1'b0;
            owner_sh_q   <= '0;
            win_sh_q     <= '0;
            cur_en_sh_q  <= 1'b0;
            cur_idx_sh_q <= '0;
            frame_cnt_q  <= '0;
            blink_ph_q   <= 1'b1;
        end else begin
            vsync_d_q <= vsync_in;
            if (w_vsync_rise) begin
                owner_sh_q   <= cell_owner;
                win_sh_q     <= win_mask;
                cur_en_sh_q  <= cursor_en;
                cur_idx_sh_q <= cursor_idx;
                if (win_mask == '0) begin
                    frame_cnt_q <= '0;
                    blink_ph_q  <= 1'b1;
                end else if (frame_cnt_q == FC_LAST) begin
                    frame_cnt_q <= '0;
                    blink_ph_q  <= ~blink_ph_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FC_W'(1);
                end
            end
        end
    end

    // Stage 1: cell coordinates from parallel range compares
    logic [31:0] w_h32, w_v32;
    logic [1:0]  col_d, row_d, col_q, row_q;
    logic        in_grid_d, in_grid_q, en1_q;
    logic [10:0] h1_q, v1_q;
    logic        hs1_q, hb1_q, vs1_q, vb1_q;
    logic [11:0] rgb1_q;

    assign w_h32 = {21'd0, hcount_in};
    assign w_v32 = {21'd0, vcount_in};

    always_comb begin
        col_d = '0;
        row_d = '0;
        for (int unsigned c = 1; c < N; c++) begin
            if (w_h32 >= GRID_X0 + c * CELL_W) col_d = 2'(c);
            if (w_v32 >= GRID_Y0 + c * CELL_H) row_d = 2'(c);
        end
        in_grid_d = (w_h32 >= GRID_X0) && (w_h32 < X_HI) &&
                    (w_v32 >= GRID_Y0) && (w_v32 < Y_HI);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            in_grid_q <= 1'b0;
            en1_q     <= 1'b0;
            h1_q      <= '0;
            hs1_q     <= 1'b0;
            hb1_q     <= 1'b0;
            v1_q      <= '0;
            vs1_q     <= 1'b0;
            vb1_q     <= 1'b0;
            rgb1_q    <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            in_grid_q <= in_grid_d;
            en1_q     <= start_en & ~choice_en;
            h1_q      <= hcount_in;
            hs1_q     <= hsync_in;
            hb1_q     <= hblnk_in;
            v1_q      <= vcount_in;
            vs1_q     <= vsync_in;
            vb1_q     <= vblnk_in;
            rgb1_q    <= rgb_in;
        end
    end

    // Stage 2: cell lookup and colour priority
    logic [3:0]  w_idx;
    logic [1:0]  w_own;
    logic        w_win;
    logic        w_cur_hit;
    logic [11:0] rgb_d;

    assign w_idx     = {2'b00, row_q} * 4'(N) + {2'b00, col_q};
    assign w_cur_hit = cur_en_sh_q &&
                       ({{(32-IDX_W){1'b0}}, cur_idx_sh_q} == {28'd0, w_idx});

    always_comb begin
        w_own = 2'b00;
        w_win = 1'b0;
        for (int unsigned k = 0; k < NN; k++) begin
            if (w_idx == 4'(k)) begin
                w_own = owner_sh_q[2*k +: 2];
                w_win = win_sh_q[k];
            end
        end
    end

    always_comb begin
        rgb_d = rgb1_q;
        if (en1_q && in_grid_q && !(w_win && !blink_ph_q)) begin
            case (w_own)
                2'b01:   rgb_d = COLOR_P0;
                2'b10:   rgb_d = COLOR_P1;
                2'b11:   rgb_d = rgb1_q;
                default: rgb_d = w_cur_hit ? COLOR_CUR : rgb1_q;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= h1_q;
            hsync_out  <= hs1_q;
            hblnk_out  <= hb1_q;
            vcount_out <= v1_q;
            vsync_out  <= vs1_q;
            vblnk_out  <= vb1_q;
            rgb_out    <= rgb_d;
        end
    end

endmodule
`default_nettype wire
